// File: rtl/lsu_mem_access.sv
// lsu_mem_access: memory-side half of the LSU. Takes an effective address, a
// load/store uOP and store data, and runs a single req/gnt/rvalid access on the
// data-memory port. Stores get lane-replicated write data and byte enables;
// loads get byte/half extraction with sign or zero extension. Misaligned
// accesses, unsupported uOPs and response timeouts end the access with a flag.
// Latency: enable -> done_out is 4 cycles (counting the enable cycle) with zero
//   wait states; every cycle of grant or response delay adds one.
// Backpressure: one access at a time; enable_in is only sampled while
//   busy_out=0, and the port holds its request until mem_gnt_in.
//
// Ports:
//   clock_in, reset_in             clock, async active-low reset
//   enable_in, uop_in, addr_in,    request from the address stage
//   store_data_in
//   busy_out, done_out,            status; done_out and the error flags are
//   misaligned_out, bus_err_out,   one-cycle pulses
//   illegal_out, load_data_out     load result, held until the next load
//   mem_*                          data-memory request/response port
module lsu_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        enable_in,
  input  logic [3:0]  uop_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] load_data_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output logic        illegal_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [3:0]  mem_be_out,
  output logic [31:0] mem_wdata_out,
  input  logic        mem_gnt_in,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic             TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  // Count value seen during the last permitted RESP cycle.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t           state_q;
  logic [3:0]       uop_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, mis_q, err_q, ill_q;
  logic [31:0]      load_data_q;
  logic             req_q, we_q;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       be_q;

  // Decode of the incoming request (only consumed in IDLE).
  logic        legal_d;
  logic [1:0]  size_d;
  logic        misal_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  always_comb begin
    legal_d = 1'b1;
    size_d  = SZ_BYTE;
    case (uop_in)
      4'b0001, 4'b0101, 4'b1001: size_d = SZ_BYTE;
      4'b0010, 4'b0110, 4'b1010: size_d = SZ_HALF;
      4'b0011, 4'b1100:          size_d = SZ_WORD;
      default:                   legal_d = 1'b0;
    endcase

    misal_d = 1'b0;
    be_d    = 4'b1111;
    wdata_d = store_data_in;
    case (size_d)
      SZ_BYTE: begin
        be_d    = 4'b0001 << addr_in[1:0];
        wdata_d = {4{store_data_in[7:0]}};
      end
      SZ_HALF: begin
        misal_d = addr_in[0];
        be_d    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data_in[15:0]}};
      end
      default: begin
        misal_d = (addr_in[1:0] != 2'b00);
      end
    endcase
  end

  // Load extraction from the returned word using the latched address offset.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = mem_rdata_in[{off_q, 3'b000} +: 8];
    ld_half = mem_rdata_in[{off_q[1], 4'b0000} +: 16];
    case (uop_q)
      4'b0001: ld_ext = {{24{ld_byte[7]}}, ld_byte};
      4'b0101: ld_ext = {24'h0, ld_byte};
      4'b0010: ld_ext = {{16{ld_half[15]}}, ld_half};
      4'b0110: ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata_in;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= S_IDLE;
      uop_q       <= 4'h0;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
      ill_q       <= 1'b0;
      load_data_q <= 32'h0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_in) begin
            uop_q  <= uop_in;
            off_q  <= addr_in[1:0];
            busy_q <= 1'b1;
            if (!legal_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              ill_q   <= 1'b1;
            end else if (misal_d) begin
              // Rejected before any bus activity.
              state_q <= S_DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              we_q    <= uop_in[3];
              addr_q  <= {addr_in[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
            end
          end
        end

        S_REQ: begin
          // Request fields stay frozen until the grant; the port is then
          // cleared so nothing stale is left on the bus.
          if (mem_gnt_in) begin
            state_q <= S_RESP;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
          end
        end

        S_RESP: begin
          // rvalid is tested first so it wins over a same-cycle timeout.
          if (mem_rvalid_in) begin
            if (!uop_q[3]) load_data_q <= ld_ext;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_LAST)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          // DONE: enable_in is ignored here; next request accepted in IDLE.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          mis_q   <= 1'b0;
          err_q   <= 1'b0;
          ill_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign load_data_out  = load_data_q;
  assign misaligned_out = mis_q;
  assign bus_err_out    = err_q;
  assign illegal_out    = ill_q;
  assign mem_req_out    = req_q;
  assign mem_we_out     = we_q;
  assign mem_addr_out   = addr_q;
  assign mem_be_out     = be_q;
  assign mem_wdata_out  = wdata_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
module tb_lsu_mem_access;

  logic        clock_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        enable_in = 1'b0;
  logic [3:0]  uop_in = 4'h0;
  logic [31:0] addr_in = 32'h0;
  logic [31:0] store_data_in = 32'h0;
  logic        busy_out, done_out, misaligned_out, bus_err_out, illegal_out;
  logic [31:0] load_data_out;
  logic        mem_req_out, mem_we_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic [3:0]  mem_be_out;
  logic        mem_gnt_in = 1'b0;
  logic        mem_rvalid_in = 1'b0;
  logic [31:0] mem_rdata_in = 32'h0;

  always #5 clock_in = ~clock_in;

  lsu_mem_access #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .enable_in(enable_in),
    .uop_in(uop_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .busy_out(busy_out), .done_out(done_out), .load_data_out(load_data_out),
    .misaligned_out(misaligned_out), .bus_err_out(bus_err_out),
    .illegal_out(illegal_out), .mem_req_out(mem_req_out),
    .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_be_out(mem_be_out), .mem_wdata_out(mem_wdata_out),
    .mem_gnt_in(mem_gnt_in), .mem_rvalid_in(mem_rvalid_in),
    .mem_rdata_in(mem_rdata_in)
  );

  int total = 0;
  int bad   = 0;

  // Observations of the most recent access.
  int          obs_done_k;      // negedges after enable until done_out seen, -1 = never
  int          obs_req_n;       // cycles with mem_req_out=1
  bit          obs_unstable;
  bit          obs_we;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_ld;
  bit          obs_mis, obs_err, obs_ill;
  bit          obs_done_after, obs_busy_after, obs_busy_gap;

  // Runs one access from a negedge. gnt_delay = REQ cycles with gnt low before
  // the grant; rv_delay = RESP cycles before rvalid (-1 = never).
  task automatic run_access(input logic [3:0] uop, input logic [31:0] addr,
                            input logic [31:0] sd, input int gnt_delay,
                            input int rv_delay, input logic [31:0] rdata);
    int  resp_n;
    bit  in_resp;
    obs_done_k = -1; obs_req_n = 0; obs_unstable = 0; obs_we = 0;
    obs_be = 4'h0; obs_addr = 32'h0; obs_wdata = 32'h0; obs_ld = 32'h0;
    obs_mis = 0; obs_err = 0; obs_ill = 0; obs_busy_gap = 0;
    resp_n = 0; in_resp = 0;
    enable_in = 1'b1; uop_in = uop; addr_in = addr; store_data_in = sd;
    mem_rdata_in = rdata; mem_gnt_in = 1'b0; mem_rvalid_in = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock_in);
      enable_in = 1'b0;
      if (mem_gnt_in) in_resp = 1;
      mem_gnt_in = 1'b0;
      mem_rvalid_in = 1'b0;
      if (done_out) begin
        obs_done_k = k; obs_mis = misaligned_out; obs_err = bus_err_out;
        obs_ill = illegal_out; obs_ld = load_data_out;
        break;
      end
      if (!busy_out) obs_busy_gap = 1;
      if (mem_req_out) begin
        obs_req_n++;
        if (obs_req_n == 1) begin
          obs_we = mem_we_out; obs_be = mem_be_out;
          obs_addr = mem_addr_out; obs_wdata = mem_wdata_out;
        end else if (mem_we_out !== obs_we || mem_be_out !== obs_be ||
                     mem_addr_out !== obs_addr || mem_wdata_out !== obs_wdata) begin
          obs_unstable = 1;
        end
        if (obs_req_n == gnt_delay + 1) mem_gnt_in = 1'b1;
      end else if (in_resp) begin
        resp_n++;
        if (rv_delay >= 0 && resp_n == rv_delay + 1) mem_rvalid_in = 1'b1;
      end
    end
    @(negedge clock_in);
    obs_done_after = done_out;
    obs_busy_after = busy_out;
  endtask

  task automatic test_reset();
    #1 reset_in = 1'b0;
    #7;
    total++;
    if ({busy_out, done_out, misaligned_out, bus_err_out, illegal_out} !== 5'b0) begin
      bad++; $display("FAIL reset_status: got %b want 00000",
                      {busy_out, done_out, misaligned_out, bus_err_out, illegal_out});
    end
    total++;
    if (load_data_out !== 32'h0) begin
      bad++; $display("FAIL reset_load_data: got %h want 00000000", load_data_out);
    end
    total++;
    if ({mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out} !== 70'h0) begin
      bad++; $display("FAIL reset_mem_port: req=%b we=%b addr=%h be=%b wdata=%h want all 0",
                      mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out);
    end
    @(negedge clock_in);
    reset_in = 1'b1;
    @(negedge clock_in);
    total++;
    if (busy_out !== 1'b0) begin
      bad++; $display("FAIL reset_release_busy: got %b want 0", busy_out);
    end
  endtask

  task automatic test_load_byte();
    run_access(4'b0001, 32'h0000_1003, 32'h0, 0, 0, 32'h80AA_BBCC);
    total++;
    if (obs_done_k !== 3) begin
      bad++; $display("FAIL lb_latency: done after %0d negedges want 3", obs_done_k);
    end
    total++;
    if (obs_be !== 4'b1000 || obs_addr !== 32'h0000_1000 || obs_we !== 1'b0) begin
      bad++; $display("FAIL lb_request: be=%b addr=%h we=%b want be=1000 addr=00001000 we=0",
                      obs_be, obs_addr, obs_we);
    end
    total++;
    if (obs_ld !== 32'hFFFF_FF80) begin
      bad++; $display("FAIL lb_data: got %h want ffffff80", obs_ld);
    end
    total++;
    if (obs_req_n !== 1 || obs_busy_gap !== 1'b0) begin
      bad++; $display("FAIL lb_req_cycles: req=%0d busy_gap=%b want 1 0", obs_req_n, obs_busy_gap);
    end
    total++;
    if (obs_done_after !== 1'b0 || obs_busy_after !== 1'b0) begin
      bad++; $display("FAIL lb_done_pulse: done=%b busy=%b after DONE want 0 0",
                      obs_done_after, obs_busy_after);
    end
  endtask

  task automatic test_load_half();
    run_access(4'b0110, 32'h0000_2002, 32'h0, 0, 0, 32'hBEEF_1234);
    total++;
    if (obs_ld !== 32'h0000_BEEF || obs_be !== 4'b1100) begin
      bad++; $display("FAIL lhu_data: got %h be=%b want 0000beef be=1100", obs_ld, obs_be);
    end
    run_access(4'b0010, 32'h0000_2002, 32'h0, 0, 0, 32'hBEEF_1234);
    total++;
    if (obs_ld !== 32'hFFFF_BEEF || obs_done_k !== 3) begin
      bad++; $display("FAIL lh_data: got %h k=%0d want ffffbeef k=3", obs_ld, obs_done_k);
    end
  endtask

  task automatic test_store_half_wait();
    run_access(4'b1010, 32'h0000_3002, 32'h0000_CAFE, 3, 0, 32'h0);
    total++;
    if (obs_we !== 1'b1 || obs_be !== 4'b1100 || obs_addr !== 32'h0000_3000 ||
        obs_wdata !== 32'hCAFE_CAFE) begin
      bad++; $display("FAIL sh_request: we=%b be=%b addr=%h wdata=%h want 1 1100 00003000 cafecafe",
                      obs_we, obs_be, obs_addr, obs_wdata);
    end
    total++;
    if (obs_req_n !== 4 || obs_unstable !== 1'b0) begin
      bad++; $display("FAIL sh_req_hold: req_cycles=%0d unstable=%b want 4 0", obs_req_n, obs_unstable);
    end
    total++;
    if (obs_done_k !== 6 || obs_mis !== 1'b0 || obs_err !== 1'b0) begin
      bad++; $display("FAIL sh_done: k=%0d mis=%b err=%b want 6 0 0", obs_done_k, obs_mis, obs_err);
    end
    total++;
    if (obs_ld !== 32'hFFFF_BEEF) begin
      bad++; $display("FAIL sh_load_hold: got %h want ffffbeef", obs_ld);
    end
  endtask

  task automatic test_misaligned();
    run_access(4'b0011, 32'h0000_4001, 32'h0, 0, 0, 32'h0);
    total++;
    if (obs_done_k !== 1 || obs_mis !== 1'b1 || obs_req_n !== 0) begin
      bad++; $display("FAIL lw_misaligned: k=%0d mis=%b req_cycles=%0d want 1 1 0",
                      obs_done_k, obs_mis, obs_req_n);
    end
    run_access(4'b1001, 32'h0000_4001, 32'h1234_56A5, 0, 0, 32'h0);
    total++;
    if (obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5_A5A5 || obs_addr !== 32'h0000_4000) begin
      bad++; $display("FAIL sb_request: be=%b wdata=%h addr=%h want 0010 a5a5a5a5 00004000",
                      obs_be, obs_wdata, obs_addr);
    end
    total++;
    if (obs_mis !== 1'b0 || obs_done_k !== 3) begin
      bad++; $display("FAIL sb_done: mis=%b k=%0d want 0 3", obs_mis, obs_done_k);
    end
  endtask

  task automatic test_timeout();
    run_access(4'b0011, 32'h0000_6000, 32'h0, 0, -1, 32'h5555_5555);
    total++;
    if (obs_done_k !== 18 || obs_err !== 1'b1) begin
      bad++; $display("FAIL timeout_err: k=%0d err=%b want 18 1", obs_done_k, obs_err);
    end
    total++;
    if (obs_ld !== 32'hFFFF_BEEF) begin
      bad++; $display("FAIL timeout_load_hold: got %h want ffffbeef", obs_ld);
    end
    run_access(4'b0011, 32'h0000_6004, 32'h0, 0, 15, 32'h0BAD_F00D);
    total++;
    if (obs_done_k !== 18 || obs_err !== 1'b0 || obs_ld !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL rvalid_last_cycle: k=%0d err=%b data=%h want 18 0 0badf00d",
                      obs_done_k, obs_err, obs_ld);
    end
  endtask

  task automatic test_illegal();
    run_access(4'b0111, 32'h0000_0000, 32'h0, 0, 0, 32'h0);
    total++;
    if (obs_ill !== 1'b1 || obs_done_k !== 1 || obs_req_n !== 0) begin
      bad++; $display("FAIL illegal_0111: ill=%b k=%0d req=%0d want 1 1 0", obs_ill, obs_done_k, obs_req_n);
    end
    run_access(4'b0000, 32'h0000_0000, 32'h0, 0, 0, 32'h0);
    total++;
    if (obs_ill !== 1'b1 || obs_mis !== 1'b0) begin
      bad++; $display("FAIL illegal_0000: ill=%b mis=%b want 1 0", obs_ill, obs_mis);
    end
  endtask

  // enable held high: sampled in IDLE, ignored in DONE.
  task automatic test_enable_in_done();
    logic [3:0] seen;
    enable_in = 1'b1; uop_in = 4'b0011; addr_in = 32'h0000_7002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_in);
      seen[i] = done_out;
    end
    enable_in = 1'b0;
    @(negedge clock_in);
    @(negedge clock_in);
    total++;
    if (seen !== 4'b0101) begin
      bad++; $display("FAIL enable_in_done: done pattern %b want 0101", seen);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [2:0] late_done;
    enable_in = 1'b1; uop_in = 4'b0011; addr_in = 32'h0000_5000;
    mem_gnt_in = 1'b1; mem_rvalid_in = 1'b0;
    @(negedge clock_in);
    enable_in = 1'b0;
    @(negedge clock_in);
    mem_gnt_in = 1'b0;
    @(negedge clock_in);
    total++;
    if (busy_out !== 1'b1 || mem_req_out !== 1'b0) begin
      bad++; $display("FAIL mid_resp_state: busy=%b req=%b want 1 0", busy_out, mem_req_out);
    end
    #2 reset_in = 1'b0;
    #1;
    total++;
    if ({busy_out, done_out, misaligned_out, bus_err_out, illegal_out, mem_req_out} !== 6'b0 ||
        load_data_out !== 32'h0) begin
      bad++; $display("FAIL async_reset_outputs: status=%b load=%h want 000000 00000000",
                      {busy_out, done_out, misaligned_out, bus_err_out, illegal_out, mem_req_out},
                      load_data_out);
    end
    @(negedge clock_in);
    reset_in = 1'b1;
    late_done = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_in);
      late_done[i] = done_out | busy_out;
    end
    total++;
    if (late_done !== 3'b000) begin
      bad++; $display("FAIL reset_abandon: done|busy pattern %b want 000", late_done);
    end
    run_access(4'b0011, 32'h0000_4000, 32'h0, 0, 0, 32'h1234_5678);
    total++;
    if (obs_done_k !== 3 || obs_ld !== 32'h1234_5678 || obs_err !== 1'b0) begin
      bad++; $display("FAIL lw_after_reset: k=%0d data=%h err=%b want 3 12345678 0",
                      obs_done_k, obs_ld, obs_err);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_half();
    test_store_half_wait();
    test_misaligned();
    test_timeout();
    test_illegal();
    test_enable_in_done();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
